// File: rtl/led16_serial_driver.sv
// -----------------------------------------------------------------------------
// led16_serial_driver
//
// Serial LED-bank driver for a 74HC595-style shift-register chain. Each rising
// edge of the board sync pulse snapshots a parallel pattern word and shifts it
// out MSB-first. When all bits are out, the driver pulses the storage latch.
//
// Parameters:
//   WIDTH  bits shifted per frame (>= 2)
//   DIV    system-clock cycles per serial-clock half period (>= 1)
//
// Ports:
//   clk        system clock, all logic on its rising edge
//   rst        synchronous, active-high reset
//   sync       sync pulse from the generator (may be several cycles wide)
//   data       pattern word, sampled only on a sync rising edge
//   busy       high while a frame is in progress
//   done       one-cycle pulse at frame completion
//   led_clk    serial shift clock to the chain
//   led_do     serial data to the chain
//   led_latch  storage-register latch strobe
//
// Configuration macro:
//   LED16_INVERT_EN  when defined, led_do carries the inverted shift bit
//                    for active-low LED banks. Framing and timing do not
//                    change, and led_do stays 0 outside the shift states.
//
// Frame length is (2*WIDTH+1)*DIV cycles. The first DIV-cycle half period
// starts on the cycle after the start edge.
// -----------------------------------------------------------------------------
module led16_serial_driver #(
  parameter int WIDTH = 16,
  parameter int DIV   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync,
  input  logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic             led_clk,
  output logic             led_do,
  output logic             led_latch
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam int DW = $clog2(DIV) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

`ifdef LED16_INVERT_EN
  localparam logic INVERT = 1'b1;
`else
  localparam logic INVERT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LATCH
  } state_t;

  state_t           state, state_nxt;
  logic             sync_d;
  logic [WIDTH-1:0] shreg, shreg_nxt;
  logic [BW-1:0]    bit_cnt, bit_cnt_nxt;
  logic [DW-1:0]    div_cnt, div_cnt_nxt;
  logic             busy_nxt, done_nxt, led_clk_nxt, led_do_nxt, led_latch_nxt;
  logic             start, div_last;

  assign start    = sync & ~sync_d;
  assign div_last = (div_cnt == DIV_LAST);

  // Next-state and next-output logic. Outputs are computed from the state
  // being entered, so that every output can come straight from a flop.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_nxt   = state;
    shreg_nxt   = shreg;
    bit_cnt_nxt = bit_cnt;
    div_cnt_nxt = div_cnt + 1'b1;

    unique case (state)
      IDLE: begin
        if (start) begin
          shreg_nxt   = data;
          bit_cnt_nxt = '0;
          state_nxt   = SHIFT_LO;
        end
      end
      SHIFT_LO: begin
        if (div_last) state_nxt = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (div_last) begin
          shreg_nxt   = shreg << 1;
          bit_cnt_nxt = bit_cnt + 1'b1;
          state_nxt   = (bit_cnt == BIT_LAST) ? LATCH : SHIFT_LO;
        end
      end
      LATCH: begin
        if (div_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    // The divide counter restarts on every state change and holds at 0 in IDLE.
    if (state_nxt != state || state == IDLE) div_cnt_nxt = '0;

    busy_nxt      = (state_nxt != IDLE);
    done_nxt      = (state == LATCH) && (state_nxt == IDLE);
    led_clk_nxt   = (state_nxt == SHIFT_HI);
    led_latch_nxt = (state_nxt == LATCH);
    // led_do changes only when leaving SHIFT_HI, which is the falling edge of
    // led_clk. It is therefore stable a full half period on both sides of
    // each rising edge.
    led_do_nxt    = ((state_nxt == SHIFT_LO) || (state_nxt == SHIFT_HI))
                    ? (shreg_nxt[WIDTH-1] ^ INVERT) : 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then updates from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      // sync_d resets high. A sync held high through reset release then
      // needs a fresh rising edge before it can start a frame.
      sync_d    <= 1'b1;
      shreg     <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      led_clk   <= 1'b0;
      led_do    <= 1'b0;
      led_latch <= 1'b0;
    end else begin
      state     <= state_nxt;
      sync_d    <= sync;
      shreg     <= shreg_nxt;
      bit_cnt   <= bit_cnt_nxt;
      div_cnt   <= div_cnt_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      led_clk   <= led_clk_nxt;
      led_do    <= led_do_nxt;
      led_latch <= led_latch_nxt;
    end
  end

endmodule

// File: tb/tb_led16_serial_driver.sv
// -----------------------------------------------------------------------------
// tb_led16_serial_driver
//
// Testbench with two instances of led16_serial_driver:
//   u_a  default parameters (WIDTH=16, DIV=4)
//   u_b  WIDTH=2, DIV=1, used for back-to-back framing
// The reference model predicts the outputs from the frame timeline. It counts
// cycles since the start edge and derives bit index, clock phase and latch
// window arithmetically. The bench compares the model against both instances
// on every falling clock edge.
// -----------------------------------------------------------------------------
module tb_led16_serial_driver;

`ifdef LED16_INVERT_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif
  localparam logic [15:0] MASK_A = {16{INV}};
  localparam logic [3:0]  MASK_B = {4{INV}};

  logic clk;
  logic rst_a, sync_a, busy_a, done_a, led_clk_a, led_do_a, led_latch_a;
  logic [15:0] data_a;
  logic rst_b, sync_b, busy_b, done_b, led_clk_b, led_do_b, led_latch_b;
  logic [1:0] data_b;

  led16_serial_driver #(.WIDTH(16), .DIV(4)) u_a (
    .clk(clk), .rst(rst_a), .sync(sync_a), .data(data_a),
    .busy(busy_a), .done(done_a), .led_clk(led_clk_a),
    .led_do(led_do_a), .led_latch(led_latch_a)
  );

  led16_serial_driver #(.WIDTH(2), .DIV(1)) u_b (
    .clk(clk), .rst(rst_b), .sync(sync_b), .data(data_b),
    .busy(busy_b), .done(done_b), .led_clk(led_clk_b),
    .led_do(led_do_b), .led_latch(led_latch_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (index 0 = u_a, 1 = u_b) ----------------
  int          mw [2] = '{16, 2};
  int          md [2] = '{4, 1};
  bit          m_active [2];
  int          m_k [2];
  logic [15:0] m_data [2];
  bit          m_sp [2];
  bit          m_done [2];

  // Advance the model by one clock edge, given the inputs seen at that edge.
  task automatic model_edge(input int i, input bit r, input bit s, input logic [15:0] d);
    int f;
    bit st;
    f = (2 * mw[i] + 1) * md[i];
    if (r) begin
      m_active[i] = 0; m_k[i] = 0; m_sp[i] = 1; m_done[i] = 0;
    end else begin
      st = s & ~m_sp[i];
      m_sp[i] = s;
      if (m_active[i]) begin
        m_k[i]++;
        m_done[i] = (m_k[i] == f);
        if (m_done[i]) m_active[i] = 0;
      end else begin
        m_done[i] = 0;
        if (st) begin
          m_active[i] = 1; m_k[i] = 0; m_data[i] = d;
        end
      end
    end
  endtask

  // Expected {busy, done, led_clk, led_do, led_latch}.
  function automatic logic [4:0] model_out(input int i);
    int w, dv, b;
    bit hi, dout;
    w = mw[i]; dv = md[i];
    if (!m_active[i]) return {1'b0, m_done[i], 3'b000};
    if (m_k[i] < 2 * w * dv) begin
      b    = m_k[i] / (2 * dv);
      hi   = (m_k[i] % (2 * dv)) >= dv;
      dout = m_data[i][w-1-b] ^ INV;
      return {1'b1, 1'b0, hi, dout, 1'b0};
    end
    return 5'b10001;
  endfunction

  // ---------------- output monitors ----------------
  int          cyc = 0;
  logic [15:0] cap_a;
  logic [3:0]  cap_b;
  bit          clk_prev_a, clk_prev_b, busy_prev_a;
  int          lat_run, lat_w, done_cnt_a, t_done_a, busy_fall_a;
  int          done_cnt_b, t_first_done_b, low_run_b, last_gap_b;
  bit          busy_prev_b;

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge(0, rst_a, sync_a, data_a);
    model_edge(1, rst_b, sync_b, {14'b0, data_b});
    @(negedge clk);
    check("a_outputs", {busy_a, done_a, led_clk_a, led_do_a, led_latch_a}, model_out(0));
    check("b_outputs", {busy_b, done_b, led_clk_b, led_do_b, led_latch_b}, model_out(1));

    if (led_clk_a && !clk_prev_a) cap_a = {cap_a[14:0], led_do_a};
    clk_prev_a = led_clk_a;
    if (led_latch_a) lat_run++;
    else begin
      if (lat_run != 0) lat_w = lat_run;
      lat_run = 0;
    end
    if (done_a) begin done_cnt_a++; t_done_a = cyc; end
    if (!busy_a && busy_prev_a) busy_fall_a++;
    busy_prev_a = busy_a;

    if (led_clk_b && !clk_prev_b) cap_b = {cap_b[2:0], led_do_b};
    clk_prev_b = led_clk_b;
    if (done_b) begin
      if (done_cnt_b == 0) t_first_done_b = cyc;
      done_cnt_b++;
    end
    if (!busy_b) low_run_b++;
    else if (!busy_prev_b) begin last_gap_b = low_run_b; low_run_b = 0; end
    busy_prev_b = busy_b;
  endtask

  task automatic clear_mon();
    cap_a = '0; lat_w = 0; lat_run = 0; done_cnt_a = 0; t_done_a = 0; busy_fall_a = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t_start;
    logic [15:0] d;
    int w, mid;

    rst_a = 1; sync_a = 0; data_a = '0;
    rst_b = 1; sync_b = 0; data_b = '0;
    cap_b = '0; clk_prev_a = 0; clk_prev_b = 0; busy_prev_a = 0; busy_prev_b = 0;
    done_cnt_b = 0; t_first_done_b = 0; low_run_b = 0; last_gap_b = 0;
    clear_mon();

    repeat (3) tick();
    check("reset_a", {busy_a, done_a, led_clk_a, led_do_a, led_latch_a}, 5'b0);
    check("reset_b", {busy_b, done_b, led_clk_b, led_do_b, led_latch_b}, 5'b0);
    rst_a = 0; rst_b = 0;
    repeat (2) tick();

    // Basic frame: 2-cycle sync, data A5C3.
    clear_mon();
    data_a = 16'hA5C3; t_start = cyc + 1; sync_a = 1;
    tick(); tick();
    sync_a = 0; data_a = 16'h1234;
    repeat (140) tick();
    check("a5c3_stream", cap_a, 16'hA5C3 ^ MASK_A);
    check("latch_width", lat_w, 4);
    check("a5c3_done_cnt", done_cnt_a, 1);
    check("done_latency", t_done_a - t_start, 132);

    // Sync held 10 cycles plus a second pulse around frame cycle 50.
    clear_mon();
    d = 16'(($urandom));
    data_a = d; sync_a = 1;
    repeat (10) tick();
    sync_a = 0; repeat (38) tick();
    sync_a = 1; repeat (2) tick();
    sync_a = 0; repeat (100) tick();
    check("held_done_cnt", done_cnt_a, 1);
    check("held_busy_falls", busy_fall_a, 1);
    check("held_stream", cap_a, d ^ MASK_A);

    // Data changes right after the start edge must not leak into the frame.
    clear_mon();
    data_a = 16'hFFFF; sync_a = 1;
    tick();
    sync_a = 0; data_a = 16'h0000;
    repeat (140) tick();
    check("capture_stream", cap_a, 16'hFFFF ^ MASK_A);

    // Reset mid-frame aborts without done; the next frame is complete.
    clear_mon();
    data_a = 16'(($urandom)); sync_a = 1;
    tick();
    sync_a = 0;
    repeat (39) tick();
    rst_a = 1; tick();
    check("abort_outputs", {busy_a, done_a, led_clk_a, led_do_a, led_latch_a}, 5'b0);
    rst_a = 0;
    repeat (150) tick();
    check("abort_no_done", done_cnt_a, 0);
    d = 16'(($urandom));
    data_a = d; sync_a = 1; tick();
    sync_a = 0; repeat (140) tick();
    check("post_abort_stream", cap_a, d ^ MASK_A);
    check("post_abort_done", done_cnt_a, 1);

    // Sync held high through reset release does not start a frame.
    clear_mon();
    sync_a = 1; rst_a = 1;
    repeat (3) tick();
    rst_a = 0;
    repeat (20) tick();
    check("held_sync_idle", busy_a, 1'b0);
    check("held_sync_no_done", done_cnt_a, 0);
    sync_a = 0; tick();
    data_a = 16'h00FF; t_start = cyc + 1; sync_a = 1; tick();
    sync_a = 0; repeat (140) tick();
    check("00ff_stream", cap_a, 16'h00FF ^ MASK_A);
    check("00ff_latency", t_done_a - t_start, 132);
    check("idle_led_do", led_do_a, 1'b0);

    // Small instance: 5-cycle frame, then a start coincident with done.
    done_cnt_b = 0; cap_b = '0;
    data_b = 2'b10; t_start = cyc + 1; sync_b = 1; tick();
    sync_b = 0; data_b = 2'b01;
    repeat (5) tick();
    sync_b = 1; tick();
    sync_b = 0; data_b = 2'b11;
    repeat (8) tick();
    check("b_frame_len", t_first_done_b - t_start, 5);
    check("b_done_cnt", done_cnt_b, 2);
    check("b_busy_gap", last_gap_b, 1);
    check("b_stream", cap_b, 4'b1001 ^ MASK_B);

    // Randomized frames: random sync width, data noise, one ignored mid-frame pulse.
    for (int n = 0; n < 6; n++) begin
      clear_mon();
      d   = 16'(($urandom));
      w   = $urandom_range(1, 5);
      mid = $urandom_range(20, 100);
      for (int t = 0; t < 150; t++) begin
        sync_a = (t < w) || (t == mid);
        data_a = (t == 0) ? d : 16'(($urandom));
        tick();
      end
      sync_a = 0; tick();
      check("rand_stream", cap_a, d ^ MASK_A);
      check("rand_done_cnt", done_cnt_a, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
